// File: rtl/sad_window_sequencer.sv
// Horizontal SAD window sequencer: keeps a WIN-deep delay line of absolute-
// difference samples and emits one running window sum per pixel once full.
// Ports:
//   clock, reset           - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready      - input handshake; in_data is the AD sample
//   line_start             - marks the accepted sample as pixel 0 of a line
//   out_valid/out_ready    - output handshake (one-deep output register)
//   out_sum/out_col/out_last - window sum, leftmost column, last-of-line flag
//   proto_err              - sticky framing error, cleared only by reset
module sad_window_sequencer #(
   parameter int unsigned WIN    = 8,
   parameter int unsigned DATA_W = 12,
   parameter int unsigned SUM_W  = 16,
   parameter int unsigned LINE_W = 640,
   parameter int unsigned COL_W  = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              line_start,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SUM_W-1:0]  out_sum,
   output logic [COL_W-1:0]  out_col,
   output logic              out_last,
   output logic              proto_err
);

   // Pixel counter must reach LINE_W itself, which may equal 2^COL_W.
   localparam int unsigned PIX_W = COL_W + 1;
   localparam int unsigned PTR_W = (WIN > 1) ? $clog2(WIN) : 1;

   typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

   state_t             state_q, state_d;
   logic [SUM_W-1:0]   sum_q, sum_d;
   logic [PIX_W-1:0]   pix_q, pix_d;
   logic [PTR_W-1:0]   wptr_q, wptr_d;
   logic               out_valid_q, out_valid_d;
   logic [SUM_W-1:0]   out_sum_q, out_sum_d;
   logic [COL_W-1:0]   out_col_q, out_col_d;
   logic               out_last_q, out_last_d;
   logic               proto_err_q, proto_err_d;
   logic [DATA_W-1:0]  dline_q [WIN];
   logic               dl_we;
   logic               accept;
   logic [DATA_W-1:0]  oldest;

   assign in_ready  = !out_valid_q || out_ready;
   assign accept    = in_valid && in_ready;
   assign oldest    = dline_q[wptr_q];

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_col   = out_col_q;
   assign out_last  = out_last_q;
   assign proto_err = proto_err_q;

   // Next-state, running-sum and output-register load logic.
   always_comb begin
      state_d     = state_q;
      sum_d       = sum_q;
      pix_d       = pix_q;
      wptr_d      = wptr_q;
      out_valid_d = out_valid_q && !out_ready;
      out_sum_d   = out_sum_q;
      out_col_d   = out_col_q;
      out_last_d  = out_last_q;
      proto_err_d = proto_err_q;
      dl_we       = 1'b0;

      if (accept) begin
         if (line_start) begin
            // A line_start mid-line aborts the partial line and restarts.
            if (state_q != IDLE) proto_err_d = 1'b1;
            sum_d   = SUM_W'(in_data);
            pix_d   = PIX_W'(1);
            state_d = FILL;
            dl_we   = 1'b1;
         end else begin
            case (state_q)
               FILL: begin
                  sum_d = sum_q + SUM_W'(in_data);
                  pix_d = pix_q + PIX_W'(1);
                  dl_we = 1'b1;
               end
               RUN: begin
                  sum_d = sum_q + SUM_W'(in_data) - SUM_W'(oldest);
                  pix_d = pix_q + PIX_W'(1);
                  dl_we = 1'b1;
               end
               default: proto_err_d = 1'b1;
            endcase

            if (state_q != IDLE && pix_d >= PIX_W'(WIN)) begin
               out_valid_d = 1'b1;
               out_sum_d   = sum_d;
               out_col_d   = COL_W'(pix_d - PIX_W'(WIN));
               out_last_d  = (pix_d == PIX_W'(LINE_W));
               state_d     = (pix_d == PIX_W'(LINE_W)) ? IDLE : RUN;
            end
         end

         if (dl_we) wptr_d = (wptr_q == PTR_W'(WIN - 1)) ? '0 : wptr_q + PTR_W'(1);
      end
   end

   // Control and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         sum_q       <= '0;
         pix_q       <= '0;
         wptr_q      <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_col_q   <= '0;
         out_last_q  <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sum_q       <= sum_d;
         pix_q       <= pix_d;
         wptr_q      <= wptr_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_col_q   <= out_col_d;
         out_last_q  <= out_last_d;
         proto_err_q <= proto_err_d;
      end
   end

   // Delay line; the oldest sample is read at wptr_q before this write.
   always_ff @(posedge clock) begin
      if (dl_we) dline_q[wptr_q] <= in_data;
   end

endmodule

// File: tb/tb_sad_window_sequencer.sv
// Scoreboard bench for sad_window_sequencer (WIN=8, LINE_W=640).
module tb_sad_window_sequencer;

   localparam int unsigned WIN    = 8;
   localparam int unsigned DATA_W = 12;
   localparam int unsigned SUM_W  = 16;
   localparam int unsigned LINE_W = 640;
   localparam int unsigned COL_W  = 10;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic              line_start = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [SUM_W-1:0]  out_sum;
   logic [COL_W-1:0]  out_col;
   logic              out_last;
   logic              proto_err;

   typedef struct {
      int unsigned sum;
      int unsigned col;
      bit          last;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   event stall_ev;

   sad_window_sequencer #(
      .WIN(WIN), .DATA_W(DATA_W), .SUM_W(SUM_W), .LINE_W(LINE_W), .COL_W(COL_W)
   ) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .line_start(line_start),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_col(out_col), .out_last(out_last),
      .proto_err(proto_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every output transfer is compared against the scoreboard head.
   always @(negedge clock) begin
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_sum", 32'(out_sum), e.sum);
            chk("out_col", 32'(out_col), e.col);
            chk("out_last", 32'(out_last), 32'(e.last));
         end
      end
   end

   // Backpressure: hold out_ready low for 5 cycles and check the output freezes.
   initial begin
      forever begin
         @(stall_ev);
         out_ready = 1'b0;
         repeat (5) begin
            @(negedge clock);
            chk("stall_in_ready", 32'(in_ready), 0);
            chk("stall_out_valid", 32'(out_valid), 1);
            if (exp_q.size() > 0) begin
               chk("stall_out_sum", 32'(out_sum), exp_q[0].sum);
               chk("stall_out_col", 32'(out_col), exp_q[0].col);
            end
            @(posedge clock);
         end
         #1 out_ready = 1'b1;
      end
   end

   // Drive one sample; the accept happens at the first edge with in_ready=1.
   task automatic send(input int unsigned data, input bit ls,
                       input bit push, input exp_t e);
      int waited = 0;
      in_valid   = 1'b1;
      in_data    = DATA_W'(data);
      line_start = ls;
      forever begin
         @(negedge clock);
         if (in_ready) break;
         waited++;
         if (waited > 100) begin
            chk("in_ready_timeout", 0, 1);
            break;
         end
      end
      if (push) exp_q.push_back(e);
      @(posedge clock);
      #1;
      in_valid   = 1'b0;
      line_start = 1'b0;
   endtask

   // kind 0: constant value, kind 1: ramp (data = pixel index).
   task automatic send_line(input int kind, input int n, input int unsigned value,
                            input int stall_at, input bit lat_chk);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         int unsigned d;
         bit push;
         d      = (kind == 1) ? 32'(i) : value;
         push   = (i >= WIN - 1);
         e.col  = 32'(i) - (WIN - 1);
         e.sum  = (kind == 1) ? 8 * e.col + 28 : 8 * value;
         e.last = (i == LINE_W - 1);
         send(d, (i == 0), push, e);
         if (lat_chk && i == WIN - 2) chk("latency_before_full", 32'(out_valid), 0);
         if (lat_chk && i == WIN - 1) chk("latency_first_valid", 32'(out_valid), 1);
         if (i == stall_at) -> stall_ev;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clock);
         n++;
      end
      chk("drain_remaining", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   initial begin
      exp_t none;
      none = '{sum: 0, col: 0, last: 1'b0};

      do_reset();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_sum", 32'(out_sum), 0);
      chk("rst_out_col", 32'(out_col), 0);
      chk("rst_out_last", 32'(out_last), 0);
      chk("rst_proto_err", 32'(proto_err), 0);
      chk("rst_in_ready", 32'(in_ready), 1);

      send_line(0, LINE_W, 1, -1, 1'b1);
      send_line(1, LINE_W, 0, 300, 1'b1);
      send_line(0, LINE_W, 4095, -1, 1'b1);
      drain();
      chk("clean_proto_err", 32'(proto_err), 0);

      // Sample without line_start while idle is dropped.
      send(5, 1'b0, 1'b0, none);
      @(negedge clock);
      chk("idle_drop_out_valid", 32'(out_valid), 0);
      chk("idle_drop_proto_err", 32'(proto_err), 1);

      do_reset();
      chk("rst2_proto_err", 32'(proto_err), 0);
      // Abort at pixel 100; the restarted line starts again at col 0.
      send_line(0, 100, 1, -1, 1'b0);
      send_line(0, LINE_W, 1, -1, 1'b1);
      drain();
      chk("abort_proto_err", 32'(proto_err), 1);

      do_reset();
      send_line(0, 20, 1, -1, 1'b0);
      chk("pre_rst_out_valid", 32'(out_valid), 1);
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_out_sum", 32'(out_sum), 0);
      chk("midrst_out_col", 32'(out_col), 0);
      chk("midrst_queue", exp_q.size(), 0);
      send_line(0, LINE_W, 1, -1, 1'b1);
      drain();
      chk("final_proto_err", 32'(proto_err), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sad_window_sequencer.md
Name: sad_window_sequencer

Overview:
- Controller and running-sum engine for horizontal SAD windows in the stereo matcher.
- Accepts a per-pixel absolute-difference stream, one line at a time.
- Keeps the last WIN samples in a delay line and sequences the add-new/subtract-old update (sum + new − old) to produce one window sum per pixel once the window is full.
- Sits between the pixel-difference stage and the disparity-minimum search.
- Enforces line framing and output backpressure.

Parameters:
- WIN, 8, window width in pixels; legal range 2..64.
- DATA_W, 12, width of each absolute-difference sample.
- SUM_W, 16, width of the running sum; must satisfy SUM_W ≥ DATA_W + clog2(WIN).
- LINE_W, 640, pixels per line; must satisfy LINE_W ≥ WIN.
- COL_W, 10, column index width; must satisfy 2^COL_W ≥ LINE_W.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, in_data is valid this cycle.
- in_ready, output, 1, block accepts in_data this cycle.
- in_data, input, DATA_W, absolute-difference sample.
- line_start, input, 1, qualifies the accepted sample as the first pixel of a line.
- out_valid, output, 1, out_sum/out_col/out_last are valid.
- out_ready, input, 1, downstream accepts the output.
- out_sum, output, SUM_W, sum of the WIN most recent samples.
- out_col, output, COL_W, column of the window's leftmost pixel.
- out_last, output, 1, marks the final window of the line.
- proto_err, output, 1, sticky protocol-error flag; cleared only by reset.

Behaviour:
- Reset (synchronous, active-high), applied on the next clock edge:
  - State goes to IDLE.
  - Running sum and the pixel counter clear to 0.
  - Delay line contents are don't-care; validity is tracked by the pixel counter.
  - out_valid=0, out_sum=0, out_col=0, out_last=0, proto_err=0.
  - Reset dominates all other inputs, including mid-line.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - in_ready = !out_valid | out_ready. The output register is one deep, and in_ready is combinational from out_valid and out_ready.
  - Output transfer = out_valid & out_ready.
  - out_valid stays high, with out_sum, out_col and out_last stable, until the transfer occurs.
- States:
  - IDLE: accept without line_start → sample dropped, proto_err set, stay in IDLE. Accept with line_start → sum = in_data, pix = 1, go to FILL.
  - FILL (pix < WIN): each accept adds in_data; the subtrahend is 0; pix increments. When the accept makes pix = WIN, go to RUN and load the output register in the same cycle.
  - RUN: each accept computes sum_next = sum + in_data − oldest, where oldest is the sample accepted WIN accepts earlier. pix increments and the output register is loaded. When pix reaches LINE_W, out_last=1 and the state goes to IDLE.
- Output register contents:
  - On entering RUN, the register loads out_sum = sum_next, out_col = pix_next − WIN, out_last = (pix_next == LINE_W), and out_valid=1.
  - Latency is one clock from the accepting edge to out_valid.
  - Each line produces LINE_W − WIN + 1 outputs, with out_col running 0..LINE_W − WIN.
  - If WIN == LINE_W, the first output of the line is also its last.
- line_start accepted in FILL or RUN: abort the current line, set proto_err, and restart as if from IDLE with this sample. No output is produced for the aborted partial window.
- Arithmetic:
  - Unsigned throughout, computed at SUM_W width.
  - in_data and oldest are zero-extended.
  - The parameter constraint guarantees no overflow and no underflow; no saturation logic is required.
- Delay line: WIN × DATA_W circular buffer with a write pointer that wraps modulo WIN. The oldest value is read at the write pointer before it is overwritten.
- No accept (in_valid=0 or in_ready=0): all state holds.

Test Plan:
- Reset, then a line of 640 samples with all in_data=1 and line_start on the first → 633 outputs, out_sum=8 each, out_col 0..632, out_last only on col 632; first out_valid one clock after the 8th accept.
- Ramp in_data = column index (0..639) → out_sum at col c = 8c+28; col 0 = 28, col 632 = 5084.
- All samples 4095 → every out_sum = 32760, with no wrap.
- Hold out_ready=0 for 5 cycles mid-RUN while in_valid=1 → in_ready=0, out_sum/out_col frozen, no samples lost; the resumed sequence continues at the next col.
- Data without line_start in IDLE → dropped, proto_err=1, out_valid stays 0. line_start at pixel 100 → line restarts, next out_col=0 after 8 accepts, proto_err=1.
- Assert reset mid-RUN with out_valid=1 → next cycle out_valid=0, out_sum=0, state IDLE; a fresh line then behaves as in the first scenario.
